// File: rtl/result_bcd_sequencer.sv
// Result BCD sequencer: captures a 128-bit AES result and its expected value.
// It then presents the result one byte at a time as 3-digit BCD, computed by an
// iterative double-dabble engine (8 iterations per byte).
module result_bcd_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          enable,
  input  logic [127:0]  data_in,
  input  logic [127:0]  expected,
  output logic [11:0]   bcd_out,
  output logic [3:0]    byte_idx,
  output logic          bcd_valid,
  output logic          busy,
  output logic          is_equal
);

  localparam int unsigned SH_W   = 20;
  localparam int unsigned ITER_W = 3;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       data_q, data_d;
  logic [SH_W-1:0]    shreg_q, shreg_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        bcd_d;
  logic [3:0]         idx_d;
  logic               valid_d, busy_d, eq_d;
  logic [SH_W-1:0]    step;
  logic [3:0]         idx_next;

  // One double-dabble iteration: correct each BCD nibble >= 5, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] r);
    logic [SH_W-1:0] a;
    a = r;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[SH_W-2:0], 1'b0};
  endfunction

  // Byte i of a 128-bit word, byte 0 in the least significant position.
  function automatic logic [7:0] pick_byte(input logic [127:0] d, input logic [3:0] i);
    return d[{i, 3'b000} +: 8];
  endfunction

  // Next-state and next-output logic; load overrides any in-progress activity.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    shreg_d  = shreg_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_out;
    idx_d    = byte_idx;
    valid_d  = 1'b0;
    busy_d   = busy;
    eq_d     = is_equal;
    step     = dd_step(shreg_q);
    idx_next = byte_idx + 4'd1;

    case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        shreg_d = step;
        iter_d  = iter_q + ITER_W'(1);
        if (iter_q == ITER_LAST) begin
          bcd_d   = step[SH_W-1:8];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (enable) begin
          if (cnt_q == TICK_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_next;
            shreg_d = {12'h000, pick_byte(data_q, idx_next)};
            iter_d  = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d  = data_in;
      eq_d    = (data_in == expected);
      idx_d   = 4'd0;
      shreg_d = {12'h000, data_in[7:0]};
      iter_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      state_d = SHIFT;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      shreg_q   <= '0;
      iter_q    <= '0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      byte_idx  <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
      is_equal  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      shreg_q   <= shreg_d;
      iter_q    <= iter_d;
      cnt_q     <= cnt_d;
      bcd_out   <= bcd_d;
      byte_idx  <= idx_d;
      bcd_valid <= valid_d;
      busy      <= busy_d;
      is_equal  <= eq_d;
    end
  end

endmodule
